// File: rtl/dut_bus_arbiter_if.sv
// ============================================================================
// Module      : dut_bus_arbiter_if
// Description : Bundle of requester-side and dut-side signals around the
//               two-requester register-port arbiter.
//                 req_*  : two requesters' transaction requests (packed per
//                          requester: addr [3i+2:3i], wdata [8i+7:8i])
//                 rsp_*  : one-cycle response strobe, read data, error flag
//                 dut_*  : single write/read method pair of the dut
//               Modport 'slave' is taken by the arbiter; modport 'master' is
//               the surrounding environment (requesters plus dut).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dut_bus_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [5:0]  req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [2:0]  dut_write_address;
  logic [7:0]  dut_write_data;
  logic        dut_write_en;
  logic        dut_write_rdy;
  logic [2:0]  dut_read_address;
  logic        dut_read_en;
  logic [7:0]  dut_read_data;
  logic        dut_read_rdy;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output dut_write_address, dut_write_data, dut_write_en,
    input  dut_write_rdy,
    output dut_read_address, dut_read_en,
    input  dut_read_data, dut_read_rdy
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  dut_write_address, dut_write_data, dut_write_en,
    output dut_write_rdy,
    input  dut_read_address, dut_read_en,
    output dut_read_data, dut_read_rdy
  );
endinterface

`default_nettype wire

// File: rtl/dut_bus_arbiter.sv
// ============================================================================
// Module      : dut_bus_arbiter
// Description : Round-robin arbiter sharing the dut's single 3-bit-address
//               register port between two requesters. Each granted
//               transaction is sequenced IDLE -> ISSUE -> RESP; ISSUE is
//               bounded by a timeout so a stuck dut rdy cannot hang a
//               requester.
// Ports       : CLK          - clock, rising edge
//               RST_N        - synchronous reset, active HIGH (1 = reset)
//               bus          - dut_bus_arbiter_if.slave (requests, responses,
//                              dut write/read method signals)
//               busy         - 1 whenever the FSM is not in IDLE
//               grant_count  - accepted-transaction count, wraps
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dut_bus_arbiter #(
  parameter int TIMEOUT = 16,  // legal 1..255
  parameter int CNT_W   = 8
) (
  input  wire logic             CLK,
  input  wire logic             RST_N,
  dut_bus_arbiter_if.slave      bus,
  output logic                  busy,
  output logic [CNT_W-1:0]      grant_count
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_RESP  = 2'd2;

  localparam logic [CNT_W-1:0] c_TO_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_rr;
  logic             r_gnt;
  logic             r_write;
  logic [2:0]       r_addr;
  logic [7:0]       r_wdata;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_rdata;
  logic             r_err;
  logic [CNT_W-1:0] r_grant_count;

  logic             w_any_req;
  logic             w_gnt;
  logic             w_tgt_rdy;
  logic             w_to_hit;
  logic [1:0]       w_req_ready;
  logic [1:0]       w_rsp_valid;
  logic             w_write_en;
  logic             w_read_en;

  assign w_any_req = |bus.req_valid;
  // Both pending -> round-robin pointer decides; otherwise requester 1 is
  // granted exactly when it is the one asking.
  assign w_gnt     = (&bus.req_valid) ? r_rr : bus.req_valid[1];
  assign w_tgt_rdy = r_write ? bus.dut_write_rdy : bus.dut_read_rdy;
  // rdy wins over the timeout when both occur in the same cycle.
  assign w_to_hit  = !w_tgt_rdy && (r_cnt == c_TO_LAST);

  // State register
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (w_any_req) w_state_nxt = c_ISSUE;
      c_ISSUE: if (w_tgt_rdy || w_to_hit) w_state_nxt = c_RESP;
      c_RESP:  w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Output logic. Everything is gated by reset so that a reset sampled in
  // ISSUE or RESP drops en / suppresses the response in that same cycle.
  always_comb begin
    w_req_ready = 2'b00;
    w_rsp_valid = 2'b00;
    w_write_en  = 1'b0;
    w_read_en   = 1'b0;
    if (!RST_N) begin
      case (r_state)
        c_IDLE: begin
          if (w_any_req) w_req_ready = w_gnt ? 2'b10 : 2'b01;
        end
        c_ISSUE: begin
          w_write_en = r_write  && bus.dut_write_rdy;
          w_read_en  = !r_write && bus.dut_read_rdy;
        end
        c_RESP: begin
          w_rsp_valid = r_gnt ? 2'b10 : 2'b01;
        end
        default: ;
      endcase
    end
  end

  // Transaction datapath: latch on accept, capture result in ISSUE.
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      r_rr          <= 1'b0;
      r_gnt         <= 1'b0;
      r_write       <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_cnt         <= '0;
      r_rdata       <= '0;
      r_err         <= 1'b0;
      r_grant_count <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_any_req) begin
            r_gnt         <= w_gnt;
            r_rr          <= ~w_gnt;
            r_write       <= bus.req_write[w_gnt];
            r_addr        <= w_gnt ? bus.req_addr[5:3]   : bus.req_addr[2:0];
            r_wdata       <= w_gnt ? bus.req_wdata[15:8] : bus.req_wdata[7:0];
            r_cnt         <= '0;
            r_grant_count <= r_grant_count + CNT_W'(1);
          end
        end
        c_ISSUE: begin
          if (w_tgt_rdy) begin
            r_err   <= 1'b0;
            r_rdata <= r_write ? 8'h00 : bus.dut_read_data;
          end else if (w_to_hit) begin
            r_err   <= 1'b1;
            r_rdata <= 8'h00;
          end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready         = w_req_ready;
  assign bus.rsp_valid         = w_rsp_valid;
  assign bus.rsp_rdata         = r_rdata;
  assign bus.rsp_err           = r_err;
  assign bus.dut_write_address = r_addr;
  assign bus.dut_write_data    = r_wdata;
  assign bus.dut_write_en      = w_write_en;
  assign bus.dut_read_address  = r_addr;
  assign bus.dut_read_en       = w_read_en;
  assign busy                  = (r_state != c_IDLE);
  assign grant_count           = r_grant_count;

endmodule

`default_nettype wire

// File: tb/tb_dut_bus_arbiter.sv
// ============================================================================
// Module      : tb_dut_bus_arbiter
// Description : Directed, self-checking bench for dut_bus_arbiter. Inputs
//               change 1 ns after a rising edge; outputs are sampled 1 ns
//               later, well away from the next edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dut_bus_arbiter;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       busy;
  logic [7:0] grant_count;

  dut_bus_arbiter_if bus ();

  dut_bus_arbiter #(
    .TIMEOUT (16),
    .CNT_W   (8)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .bus         (bus),
    .busy        (busy),
    .grant_count (grant_count)
  );

  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid     = 2'b00;
    bus.req_write     = 2'b00;
    bus.req_addr      = 6'd0;
    bus.req_wdata     = 16'h0000;
    bus.dut_write_rdy = 1'b0;
    bus.dut_read_rdy  = 1'b0;
    bus.dut_read_data = 8'h00;
  endtask

  // Leaves the bench in the first IDLE cycle after reset release.
  task automatic apply_reset();
    RST_N = 1'b1;
    idle_inputs();
    next_cycle();
    next_cycle();
    RST_N = 1'b0;
  endtask

  logic en_seen;
  logic early_rsp;

  initial begin
    idle_inputs();
    apply_reset();
    settle();

    // ---- reset state ----
    check("rst_busy",       32'(busy), 32'd0);
    check("rst_grant_cnt",  32'(grant_count), 32'd0);
    check("rst_req_ready",  32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid",  32'(bus.rsp_valid), 32'd0);
    check("rst_wr_en",      32'(bus.dut_write_en), 32'd0);
    check("rst_rd_en",      32'(bus.dut_read_en), 32'd0);
    check("rst_addr",       32'(bus.dut_write_address), 32'd0);
    check("rst_rdata",      32'(bus.rsp_rdata), 32'd0);

    // ---- 1: req0 write addr 3 data A5 ----
    bus.req_valid     = 2'b01;
    bus.req_write     = 2'b01;
    bus.req_addr      = 6'd3;
    bus.req_wdata     = 16'h00A5;
    bus.dut_write_rdy = 1'b1;
    settle();
    check("t1_req_ready", 32'(bus.req_ready), 32'h1);
    next_cycle();
    bus.req_valid = 2'b00;
    settle();
    check("t1_wr_en",    32'(bus.dut_write_en), 32'd1);
    check("t1_rd_en",    32'(bus.dut_read_en), 32'd0);
    check("t1_wr_addr",  32'(bus.dut_write_address), 32'd3);
    check("t1_wr_data",  32'(bus.dut_write_data), 32'hA5);
    check("t1_busy",     32'(busy), 32'd1);
    check("t1_no_ready", 32'(bus.req_ready), 32'd0);
    next_cycle();
    settle();
    check("t1_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("t1_rsp_err",   32'(bus.rsp_err), 32'd0);
    check("t1_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("t1_grant_cnt", 32'(grant_count), 32'd1);
    check("t1_resp_wr_en", 32'(bus.dut_write_en), 32'd0);
    next_cycle();
    settle();
    check("t1_idle_busy", 32'(busy), 32'd0);

    // ---- 2: req1 read addr 5, data 3C ----
    bus.dut_write_rdy = 1'b0;
    bus.req_valid     = 2'b10;
    bus.req_write     = 2'b00;
    bus.req_addr      = {3'd5, 3'd0};
    bus.dut_read_rdy  = 1'b1;
    bus.dut_read_data = 8'h3C;
    settle();
    check("t2_req_ready", 32'(bus.req_ready), 32'h2);
    next_cycle();
    bus.req_valid = 2'b00;
    settle();
    check("t2_rd_en",   32'(bus.dut_read_en), 32'd1);
    check("t2_wr_en",   32'(bus.dut_write_en), 32'd0);
    check("t2_rd_addr", 32'(bus.dut_read_address), 32'd5);
    next_cycle();
    bus.dut_read_data = 8'h00;
    settle();
    check("t2_rsp_valid", 32'(bus.rsp_valid), 32'h2);
    check("t2_rsp_rdata", 32'(bus.rsp_rdata), 32'h3C);
    check("t2_rsp_err",   32'(bus.rsp_err), 32'd0);
    check("t2_grant_cnt", 32'(grant_count), 32'd2);

    // ---- 3: both valid, strict alternation 0,1,0,1 ----
    apply_reset();
    bus.req_valid     = 2'b11;
    bus.req_write     = 2'b11;
    bus.req_addr      = {3'd6, 3'd1};
    bus.req_wdata     = 16'hB1A0;
    bus.dut_write_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      check($sformatf("t3_ready_%0d", k), 32'(bus.req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      next_cycle();
      settle();
      check($sformatf("t3_addr_%0d", k), 32'(bus.dut_write_address), (k % 2 == 0) ? 32'd1 : 32'd6);
      check($sformatf("t3_data_%0d", k), 32'(bus.dut_write_data), (k % 2 == 0) ? 32'hA0 : 32'hB1);
      next_cycle();
      settle();
      check($sformatf("t3_rsp_%0d", k), 32'(bus.rsp_valid), (k % 2 == 0) ? 32'h1 : 32'h2);
      next_cycle();
    end
    bus.req_valid = 2'b00;
    settle();
    check("t3_grant_cnt", 32'(grant_count), 32'd4);

    // ---- 4: write timeout, rdy held low ----
    idle_inputs();
    bus.req_valid = 2'b01;
    bus.req_write = 2'b01;
    bus.req_addr  = 6'd2;
    bus.req_wdata = 16'h0011;
    settle();
    check("t4_req_ready", 32'(bus.req_ready), 32'h1);
    en_seen   = 1'b0;
    early_rsp = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      next_cycle();
      bus.req_valid = 2'b00;
      settle();
      if (bus.dut_write_en) en_seen = 1'b1;
      if (bus.rsp_valid != 2'b00) early_rsp = 1'b1;
    end
    check("t4_no_wr_en",    32'(en_seen), 32'd0);
    check("t4_no_early_rsp", 32'(early_rsp), 32'd0);
    next_cycle();
    settle();
    check("t4_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("t4_rsp_err",   32'(bus.rsp_err), 32'd1);
    check("t4_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("t4_wr_en_resp", 32'(bus.dut_write_en), 32'd0);
    next_cycle();

    // ---- 5: read, rdy low for 5 ISSUE cycles then high ----
    bus.req_valid     = 2'b10;
    bus.req_write     = 2'b00;
    bus.req_addr      = {3'd6, 3'd0};
    bus.dut_read_data = 8'h5A;
    settle();
    check("t5_req_ready", 32'(bus.req_ready), 32'h2);
    en_seen = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      bus.req_valid = 2'b00;
      settle();
      if (bus.dut_read_en) en_seen = 1'b1;
    end
    check("t5_no_early_en", 32'(en_seen), 32'd0);
    next_cycle();
    bus.dut_read_rdy = 1'b1;
    settle();
    check("t5_rd_en_c6", 32'(bus.dut_read_en), 32'd1);
    next_cycle();
    bus.dut_read_rdy = 1'b0;
    settle();
    check("t5_rsp_valid", 32'(bus.rsp_valid), 32'h2);
    check("t5_rsp_err",   32'(bus.rsp_err), 32'd0);
    check("t5_rsp_rdata", 32'(bus.rsp_rdata), 32'h5A);
    next_cycle();

    // ---- 6: reset during ISSUE ----
    idle_inputs();
    bus.req_valid = 2'b01;
    bus.req_write = 2'b01;
    bus.req_addr  = 6'd4;
    bus.req_wdata = 16'h0042;
    settle();
    check("t6_req_ready", 32'(bus.req_ready), 32'h1);
    next_cycle();
    bus.req_valid = 2'b00;
    next_cycle();
    bus.dut_write_rdy = 1'b1;
    RST_N = 1'b1;
    settle();
    check("t6_en_dropped", 32'(bus.dut_write_en), 32'd0);
    next_cycle();
    RST_N = 1'b0;
    bus.dut_write_rdy = 1'b0;
    settle();
    check("t6_busy_after", 32'(busy), 32'd0);
    early_rsp = 1'b0;
    if (bus.rsp_valid != 2'b00) early_rsp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      settle();
      if (bus.rsp_valid != 2'b00) early_rsp = 1'b1;
    end
    check("t6_no_rsp", 32'(early_rsp), 32'd0);
    bus.req_valid     = 2'b10;
    bus.req_write     = 2'b00;
    bus.req_addr      = {3'd7, 3'd0};
    bus.dut_read_rdy  = 1'b1;
    bus.dut_read_data = 8'h77;
    settle();
    check("t6_next_ready", 32'(bus.req_ready), 32'h2);
    next_cycle();
    bus.req_valid = 2'b00;
    settle();
    check("t6_next_gcnt", 32'(grant_count), 32'd1);
    next_cycle();
    settle();
    check("t6_next_rsp",   32'(bus.rsp_valid), 32'h2);
    check("t6_next_rdata", 32'(bus.rsp_rdata), 32'h77);

    // ---- grant_count wrap ----
    apply_reset();
    bus.req_valid     = 2'b01;
    bus.req_write     = 2'b01;
    bus.dut_write_rdy = 1'b1;
    for (int n = 0; n < 255; n++) begin
      next_cycle();
      next_cycle();
      next_cycle();
    end
    settle();
    check("wrap_255", 32'(grant_count), 32'd255);
    next_cycle();
    settle();
    check("wrap_0", 32'(grant_count), 32'd0);
    check("wrap_wr_en", 32'(bus.dut_write_en), 32'd1);
    next_cycle();
    next_cycle();
    settle();
    check("wrap_next_ready", 32'(bus.req_ready), 32'h1);
    next_cycle();
    settle();
    check("wrap_1", 32'(grant_count), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dut_bus_arbiter.md
Name: dut_bus_arbiter

Overview:
- Shares the single 3-bit-address register port of `dut` between two requesters (0 and 1).
- Requesters issue 8-bit write or read transactions; the block grants them round-robin, sequences each granted transaction onto the dut write or read method, and returns a one-cycle response.
- A per-transaction timeout prevents a stalled dut ready from hanging a requester.
- Sits between the requester logic and `dut_wrapper`.

Parameters:
- TIMEOUT, 16: max ISSUE cycles with the target ready low before abort; legal range 1..255.
- CNT_W, 8: width of the timeout counter and of `grant_count`.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST_N  input  1  synchronous, active-high reset (asserted = 1).
- req_valid  input  2  per requester: request pending.
- req_write  input  2  per requester: 1 = write, 0 = read.
- req_addr  input  6  requester i address at [3i+2:3i].
- req_wdata  input  16  requester i write data at [8i+7:8i].
- req_ready  output  2  per requester: request accepted this cycle; one-hot or zero.
- rsp_valid  output  2  per requester: one-cycle response strobe.
- rsp_rdata  output  8  read data, valid with rsp_valid; 0 for writes and errors.
- rsp_err  output  1  valid with rsp_valid: 1 = timeout abort.
- dut_write_address  output  3  to dut write_address.
- dut_write_data  output  8  to dut write_data.
- dut_write_en  output  1  to dut write_en.
- dut_write_rdy  input  1  from dut write_rdy.
- dut_read_address  output  3  to dut read_address.
- dut_read_en  output  1  to dut read_en.
- dut_read_data  input  8  from dut read_data.
- dut_read_rdy  input  1  from dut read_rdy.
- busy  output  1  1 in any state other than IDLE.
- grant_count  output  CNT_W  count of accepted transactions; wraps modulo 2^CNT_W.

Behaviour:
- **Reset** (RST_N=1 at a clock edge):
  - state = IDLE; round-robin pointer `rr` = 0 (requester 0 has priority).
  - All registered outputs = 0, latched address/data = 0, timeout counter = 0, `grant_count` = 0.
  - Reset mid-transaction abandons it: no response is issued, and en is deasserted the same cycle reset is sampled.
- **FSM** with states IDLE, ISSUE, RESP.
- **IDLE:**
  - If any `req_valid` bit is set, grant one requester. If both are set, grant `rr`; otherwise grant the single one.
  - Drive `req_ready[g]`=1 combinationally for the granted requester.
  - Latch write/addr/wdata and g; set `rr` = ~g; increment `grant_count`; go to ISSUE.
  - If no request is pending, stay in IDLE with `req_ready`=0.
- **ISSUE, write transaction:**
  - `dut_write_en` = `dut_write_rdy` (combinational, only in ISSUE and only for a write).
  - If `dut_write_rdy`=1, the transfer occurs this cycle → RESP with err=0, rdata=0.
- **ISSUE, read transaction:**
  - `dut_read_en` = `dut_read_rdy`.
  - If `dut_read_rdy`=1, capture `dut_read_data` this cycle → RESP with err=0.
- **En rule:** an en output is never high while its rdy is low, never in IDLE or RESP, and never for the other transaction type. Write and read en are mutually exclusive.
- **ISSUE timeout:**
  - Each ISSUE cycle with the target rdy low increments the counter.
  - When the counter equals TIMEOUT-1 and rdy is still low, go to RESP with err=1, rdata=0; no en is issued.
  - The counter clears on entry to ISSUE.
- **RESP:** `rsp_valid[g]`=1 for exactly one cycle with the registered `rsp_rdata`/`rsp_err`, then IDLE.
- **Outputs:**
  - `dut_write_address`, `dut_write_data`, `dut_read_address` are driven from latched registers and hold their values outside ISSUE.
  - `busy` = (state != IDLE).
- **Timing:**
  - Best case: accept at T, en at T+1, `rsp_valid` at T+2, next accept at T+3.
  - A requester may hold `req_valid` high continuously; it is re-arbitrated on every IDLE cycle.
- **Simultaneous events:**
  - Both requesters valid: strict alternation.
  - A request arriving during ISSUE/RESP waits; `req_ready` stays 0.
  - Rdy rising in the same cycle the counter reaches TIMEOUT-1 counts as success (err=0).
- **Wrap:** `grant_count` rolls from 2^CNT_W-1 to 0 without side effects.

Test Plan:
1. Reset, then req0 writes addr 3, data 0xA5, with `dut_write_rdy`=1:
   - `req_ready[0]` at T; `dut_write_en`=1 with addr 3 / data 0xA5 at T+1.
   - `rsp_valid[0]`=1, err=0, rdata=0 at T+2; `grant_count`=1.
2. req1 reads addr 5, with `dut_read_rdy`=1 and `dut_read_data`=0x3C at T+1 → `rsp_valid[1]` at T+2 with `rsp_rdata`=0x3C.
3. Both requesters held valid for 4 transactions after reset → grant order 0,1,0,1; `grant_count`=4.
4. Write with `dut_write_rdy` held low and TIMEOUT=16:
   - No `dut_write_en` ever asserted.
   - `rsp_err`=1 with `rsp_valid[0]` exactly 17 cycles after accept.
5. Read with `dut_read_rdy` low for 5 ISSUE cycles, then high → `dut_read_en` on cycle 6 of ISSUE; response err=0 with the correct data.
6. Assert RST_N=1 during ISSUE:
   - en drops that cycle; `rsp_valid` never pulses; `busy`=0 next cycle.
   - The next request is accepted normally.
